// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - shared RV32I pipeline encodings and helpers
package id_ex_pipe_reg_pkg;

    localparam logic [4:0] ALUOP_IDLE = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_SUB  = 5'd2;
    localparam logic [4:0] ALUOP_SLL  = 5'd3;
    localparam logic [4:0] ALUOP_SLT  = 5'd4;
    localparam logic [4:0] ALUOP_SLTU = 5'd5;
    localparam logic [4:0] ALUOP_XOR  = 5'd6;
    localparam logic [4:0] ALUOP_SRL  = 5'd7;
    localparam logic [4:0] ALUOP_SRA  = 5'd8;
    localparam logic [4:0] ALUOP_OR   = 5'd9;
    localparam logic [4:0] ALUOP_AND  = 5'd10;
    localparam logic [4:0] ALUOP_PASSB = 5'd11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // True when a source operand that is actually read names the given rd.
    function automatic logic reads_reg(input logic used, input logic [4:0] src,
                                       input logic [4:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_hazard_detect_unit.sv
// rtl/id_ex_pipe_reg_hazard_detect_unit.sv - combinational load-use hazard detector
module hazard_detect_unit
    import id_ex_pipe_reg_pkg::*;
(
    input  logic       id_valid,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_addr,
    output logic       load_use
);

    logic ex_is_load;
    logic src_match;

    // x0 is never a real destination, so a load to x0 cannot create a hazard.
    assign ex_is_load = ex_valid && ex_mem_read && (ex_rd_addr != 5'd0);
    assign src_match  = reads_reg(id_rs1_used, id_rs1_addr, ex_rd_addr)
                     || reads_reg(id_rs2_used, id_rs2_addr, ex_rd_addr);
    assign load_use   = ex_is_load && src_match && id_valid;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with hazard bubble, flush and stall hold
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_alu_op,
    input  logic            id_alu_src1_pc,
    input  logic            id_alu_src2_imm,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic [1:0]      id_wb_sel,
    input  logic [2:0]      id_funct3,
    input  logic            stall_ex,
    input  logic            flush,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd_addr,
    output logic [4:0]      ex_alu_op,
    output logic            ex_alu_src1_pc,
    output logic            ex_alu_src2_imm,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic [1:0]      ex_wb_sel,
    output logic [2:0]      ex_funct3,
    output logic            stall_if_id,
    output logic [CNT_W-1:0] perf_bubble_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [4:0]      alu_op;
        logic            alu_src1_pc;
        logic            alu_src2_imm;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
    } ex_fields_t;

    ex_fields_t       id_fields;
    ex_fields_t       ex_d, ex_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             load_use;

    hazard_detect_unit u_hazard (
        .id_valid    (id_valid),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.mem_read),
        .ex_rd_addr  (ex_q.rd_addr),
        .load_use    (load_use)
    );

    assign id_fields = '{
        valid:        id_valid,
        pc:           id_pc,
        rs1_data:     id_rs1_data,
        rs2_data:     id_rs2_data,
        imm:          id_imm,
        rs1_addr:     id_rs1_addr,
        rs2_addr:     id_rs2_addr,
        rd_addr:      id_rd_addr,
        alu_op:       id_alu_op,
        alu_src1_pc:  id_alu_src1_pc,
        alu_src2_imm: id_alu_src2_imm,
        mem_read:     id_mem_read,
        mem_write:    id_mem_write,
        reg_write:    id_reg_write,
        wb_sel:       id_wb_sel,
        funct3:       id_funct3
    };

    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (stall_ex) begin
            ex_d = ex_q;
        end else if (flush) begin
            ex_d        = '0;
            ex_d.alu_op = ALUOP_IDLE;
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (load_use) begin
            ex_d         = '0;
            ex_d.alu_op  = ALUOP_IDLE;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            ex_d = id_fields;
            // A non-instruction must not produce side effects downstream.
            if (!id_valid) begin
                ex_d.mem_read  = 1'b0;
                ex_d.mem_write = 1'b0;
                ex_d.reg_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // A flush discards the ID instruction anyway, so no need to freeze fetch for it.
    assign stall_if_id = stall_ex | (load_use & ~flush);

    assign ex_valid        = ex_q.valid;
    assign ex_pc           = ex_q.pc;
    assign ex_rs1_data     = ex_q.rs1_data;
    assign ex_rs2_data     = ex_q.rs2_data;
    assign ex_imm          = ex_q.imm;
    assign ex_rs1_addr     = ex_q.rs1_addr;
    assign ex_rs2_addr     = ex_q.rs2_addr;
    assign ex_rd_addr      = ex_q.rd_addr;
    assign ex_alu_op       = ex_q.alu_op;
    assign ex_alu_src1_pc  = ex_q.alu_src1_pc;
    assign ex_alu_src2_imm = ex_q.alu_src2_imm;
    assign ex_mem_read     = ex_q.mem_read;
    assign ex_mem_write    = ex_q.mem_write;
    assign ex_reg_write    = ex_q.reg_write;
    assign ex_wb_sel       = ex_q.wb_sel;
    assign ex_funct3       = ex_q.funct3;
    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - self-checking bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

    localparam int CW = 4;
    localparam logic [4:0] ADD = 5'd1;
    localparam logic [4:0] SUB = 5'd2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        id_valid, id_rs1_used, id_rs2_used, id_alu_src1_pc, id_alu_src2_imm;
    logic        id_mem_read, id_mem_write, id_reg_write, stall_ex, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op;
    logic [1:0]  id_wb_sel;
    logic [2:0]  id_funct3;
    logic        ex_valid, ex_alu_src1_pc, ex_alu_src2_imm, ex_mem_read, ex_mem_write;
    logic        ex_reg_write, stall_if_id;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_alu_op;
    logic [1:0]  ex_wb_sel;
    logic [2:0]  ex_funct3;
    logic [CW-1:0] perf_bubble_cnt, perf_flush_cnt;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_alu_op(id_alu_op),
        .id_alu_src1_pc(id_alu_src1_pc), .id_alu_src2_imm(id_alu_src2_imm),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .id_wb_sel(id_wb_sel), .id_funct3(id_funct3), .stall_ex(stall_ex), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr),
        .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op),
        .ex_alu_src1_pc(ex_alu_src1_pc), .ex_alu_src2_imm(ex_alu_src2_imm),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_wb_sel(ex_wb_sel), .ex_funct3(ex_funct3), .stall_if_id(stall_if_id),
        .perf_bubble_cnt(perf_bubble_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda, alu;
        logic        rs1u, rs2u, s1pc, s2imm, mr, mw, rw;
        logic [1:0]  wb;
        logic [2:0]  f3;
        logic        stall, flush;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rda, alu;
        logic        s1pc, s2imm, mr, mw, rw;
        logic [1:0]  wb;
        logic [2:0]  f3;
    } exo_t;

    typedef struct packed {
        in_t         in;
        logic        stall_if_id;
        logic        valid;
        logic [4:0]  alu;
        logic [4:0]  rd;
        logic        mr;
        logic [CW-1:0] bub;
        logic [CW-1:0] fl;
    } vec_t;

    exo_t dut_ex;
    assign dut_ex = '{valid: ex_valid, pc: ex_pc, rs1d: ex_rs1_data, rs2d: ex_rs2_data,
                      imm: ex_imm, rs1a: ex_rs1_addr, rs2a: ex_rs2_addr, rda: ex_rd_addr,
                      alu: ex_alu_op, s1pc: ex_alu_src1_pc, s2imm: ex_alu_src2_imm,
                      mr: ex_mem_read, mw: ex_mem_write, rw: ex_reg_write,
                      wb: ex_wb_sel, f3: ex_funct3};

    int checks = 0;
    int errors = 0;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input in_t v);
        id_valid = v.valid; id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d;
        id_imm = v.imm; id_rs1_addr = v.rs1a; id_rs2_addr = v.rs2a; id_rd_addr = v.rda;
        id_alu_op = v.alu; id_rs1_used = v.rs1u; id_rs2_used = v.rs2u;
        id_alu_src1_pc = v.s1pc; id_alu_src2_imm = v.s2imm; id_mem_read = v.mr;
        id_mem_write = v.mw; id_reg_write = v.rw; id_wb_sel = v.wb; id_funct3 = v.f3;
        stall_ex = v.stall; flush = v.flush;
    endtask

    function automatic in_t mk(input logic valid, input logic [31:0] pc,
                               input logic [4:0] rs1a, input logic rs1u,
                               input logic [4:0] rs2a, input logic rs2u,
                               input logic [4:0] rda, input logic [4:0] alu,
                               input logic mr, input logic stall, input logic fl);
        in_t v;
        v = '{valid: valid, pc: pc, rs1d: pc ^ 32'hA5A5_0000, rs2d: pc ^ 32'h5A5A_0000,
              imm: pc + 32'd4, rs1a: rs1a, rs2a: rs2a, rda: rda, alu: alu,
              rs1u: rs1u, rs2u: rs2u, s1pc: 1'b0, s2imm: mr, mr: mr, mw: 1'b0,
              rw: 1'b1, wb: mr ? 2'd1 : 2'd0, f3: 3'd2, stall: stall, flush: fl};
        return v;
    endfunction

    // Reference model: the instruction EX is expected to hold and the event counts.
    exo_t        m;
    logic [CW-1:0] mb, mf;

    function automatic logic model_hazard(input exo_t e, input in_t v);
        if (!(e.valid && e.mr && e.rda != 5'd0 && v.valid)) return 1'b0;
        return (v.rs1u && v.rs1a == e.rda) || (v.rs2u && v.rs2a == e.rda);
    endfunction

    initial begin
        in_t  v;
        logic hz;
        rst = 1'b1;
        drive('0);
        #12;
        chk("reset_ex_fields", dut_ex, '0);
        chk("reset_valid", ex_valid, 0);
        chk("reset_alu_idle", ex_alu_op, 0);
        chk("reset_bubble_cnt", perf_bubble_cnt, 0);
        chk("reset_flush_cnt", perf_flush_cnt, 0);
        chk("reset_stall_if_id", stall_if_id, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        //                 valid pc        rs1 u  rs2 u  rd  alu  mr stall flush   stl vld alu  rd  mr bub fl
        tbl[0]  = '{mk(1, 32'h100, 5'd1, 1, 5'd2, 1, 5'd5,  ADD, 0, 0, 0), 0, 1, ADD, 5'd5,  0, 4'd0, 4'd0};
        tbl[1]  = '{mk(1, 32'h104, 5'd2, 1, 5'd0, 0, 5'd5,  ADD, 1, 0, 0), 0, 1, ADD, 5'd5,  1, 4'd0, 4'd0};
        tbl[2]  = '{mk(1, 32'h108, 5'd5, 1, 5'd3, 1, 5'd6,  ADD, 0, 0, 0), 1, 0, 5'd0, 5'd0, 0, 4'd1, 4'd0};
        tbl[3]  = '{mk(1, 32'h108, 5'd5, 1, 5'd3, 1, 5'd6,  ADD, 0, 0, 0), 0, 1, ADD, 5'd6,  0, 4'd1, 4'd0};
        tbl[4]  = '{mk(1, 32'h10c, 5'd1, 1, 5'd0, 0, 5'd0,  ADD, 1, 0, 0), 0, 1, ADD, 5'd0,  1, 4'd1, 4'd0};
        tbl[5]  = '{mk(1, 32'h110, 5'd0, 1, 5'd0, 1, 5'd7,  ADD, 0, 0, 0), 0, 1, ADD, 5'd7,  0, 4'd1, 4'd0};
        tbl[6]  = '{mk(1, 32'h114, 5'd1, 1, 5'd0, 0, 5'd7,  ADD, 1, 0, 0), 0, 1, ADD, 5'd7,  1, 4'd1, 4'd0};
        tbl[7]  = '{mk(1, 32'h118, 5'd7, 1, 5'd0, 0, 5'd8,  ADD, 0, 0, 1), 0, 0, 5'd0, 5'd0, 0, 4'd1, 4'd1};
        tbl[8]  = '{mk(1, 32'h200, 5'd1, 1, 5'd2, 1, 5'd9,  SUB, 0, 0, 0), 0, 1, SUB, 5'd9,  0, 4'd1, 4'd1};
        tbl[9]  = '{mk(1, 32'h204, 5'd9, 1, 5'd0, 0, 5'd10, ADD, 1, 1, 1), 1, 1, SUB, 5'd9,  0, 4'd1, 4'd1};
        tbl[10] = '{mk(1, 32'h204, 5'd9, 1, 5'd0, 0, 5'd10, ADD, 1, 1, 1), 1, 1, SUB, 5'd9,  0, 4'd1, 4'd1};
        tbl[11] = '{mk(1, 32'h204, 5'd9, 1, 5'd0, 0, 5'd10, ADD, 1, 1, 1), 1, 1, SUB, 5'd9,  0, 4'd1, 4'd1};
        tbl[12] = '{mk(1, 32'h204, 5'd9, 1, 5'd0, 0, 5'd10, ADD, 1, 0, 1), 0, 0, 5'd0, 5'd0, 0, 4'd1, 4'd2};
        tbl[13] = '{mk(0, 32'h208, 5'd1, 1, 5'd0, 0, 5'd3,  SUB, 1, 0, 0), 0, 0, SUB, 5'd3,  0, 4'd1, 4'd2};
        tbl[14] = '{mk(1, 32'h20c, 5'd1, 1, 5'd0, 0, 5'd5,  ADD, 0, 0, 0), 0, 1, ADD, 5'd5,  0, 4'd1, 4'd2};

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].in);
            #3;
            chk($sformatf("row%0d_stall_if_id", i), stall_if_id, tbl[i].stall_if_id);
            @(posedge clk); #1;
            chk($sformatf("row%0d_ex_valid", i), ex_valid, tbl[i].valid);
            chk($sformatf("row%0d_ex_alu_op", i), ex_alu_op, tbl[i].alu);
            chk($sformatf("row%0d_ex_rd_addr", i), ex_rd_addr, tbl[i].rd);
            chk($sformatf("row%0d_ex_mem_read", i), ex_mem_read, tbl[i].mr);
            chk($sformatf("row%0d_bubble_cnt", i), perf_bubble_cnt, tbl[i].bub);
            chk($sformatf("row%0d_flush_cnt", i), perf_flush_cnt, tbl[i].fl);
        end
        chk("first_load_pc", ex_pc, 32'h20c);

        // Asynchronous reset mid-cycle while stalled, then a normal load after release.
        v = mk(1, 32'h300, 5'd1, 1, 5'd2, 1, 5'd12, SUB, 0, 1, 0);
        drive(v);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ex_fields", dut_ex, '0);
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_bubble_cnt", perf_bubble_cnt, 0);
        chk("async_rst_flush_cnt", perf_flush_cnt, 0);
        #2 rst = 1'b0;
        stall_ex = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_load_valid", ex_valid, 1);
        chk("post_rst_load_rd", ex_rd_addr, 5'd12);
        chk("post_rst_load_pc", ex_pc, 32'h300);

        // Randomized run against the reference model; small CNT_W exercises wrap.
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        m  = '0;
        mb = '0;
        mf = '0;
        for (int c = 0; c < 400; c++) begin
            v = '{valid: ($urandom_range(0, 9) < 8), pc: $urandom, rs1d: $urandom,
                  rs2d: $urandom, imm: $urandom, rs1a: 5'($urandom_range(0, 3)),
                  rs2a: 5'($urandom_range(0, 3)), rda: 5'($urandom_range(0, 3)),
                  alu: 5'($urandom_range(0, 11)), rs1u: 1'($urandom), rs2u: 1'($urandom),
                  s1pc: 1'($urandom), s2imm: 1'($urandom), mr: ($urandom_range(0, 1) == 1),
                  mw: 1'($urandom), rw: 1'($urandom), wb: 2'($urandom_range(0, 2)),
                  f3: 3'($urandom), stall: ($urandom_range(0, 9) < 2),
                  flush: ($urandom_range(0, 9) < 2)};
            drive(v);
            #3;
            hz = model_hazard(m, v);
            chk("rand_stall_if_id", stall_if_id, v.stall || (hz && !v.flush));
            @(posedge clk); #1;
            if (v.stall) begin
                m = m;
            end else if (v.flush) begin
                m  = '0;
                mf = mf + 1'b1;
            end else if (hz) begin
                m  = '0;
                mb = mb + 1'b1;
            end else begin
                m = '{valid: v.valid, pc: v.pc, rs1d: v.rs1d, rs2d: v.rs2d, imm: v.imm,
                      rs1a: v.rs1a, rs2a: v.rs2a, rda: v.rda, alu: v.alu, s1pc: v.s1pc,
                      s2imm: v.s2imm, mr: v.mr && v.valid, mw: v.mw && v.valid,
                      rw: v.rw && v.valid, wb: v.wb, f3: v.f3};
            end
            chk("rand_ex_fields", dut_ex, m);
            chk("rand_bubble_cnt", perf_bubble_cnt, mb);
            chk("rand_flush_cnt", perf_flush_cnt, mf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
